// File: rtl/idct_pkg.sv
// Shared definitions for the 8-point 1-D inverse DCT: widths, rounding
// constants, the cosine table (scale 2^11) and the output saturation helper.
package idct_pkg;

  localparam int IDCT_IN_W   = 12;
  localparam int IDCT_OUT_W  = 12;
  localparam int IDCT_COEF_W = 12;
  localparam int IDCT_ACC_W  = 28;

  localparam int ROUND_CONST = 1024;
  localparam int ROUND_SHIFT = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } idct_state_e;

  // IDCT_COEF[n][k] = round(2048 * c(k)/2 * cos((2n+1)k*pi/16))
  localparam int IDCT_COEF [8][8] = '{
    '{724,  1004,  946,   851,  724,   569,  392,   200},
    '{724,   851,  392,  -200, -724, -1004, -946,  -569},
    '{724,   569, -392, -1004, -724,   200,  946,   851},
    '{724,   200, -946,  -569,  724,   851, -392, -1004},
    '{724,  -200, -946,   569,  724,  -851, -392,  1004},
    '{724,  -569, -392,  1004, -724,  -200,  946,  -851},
    '{724,  -851,  392,   200, -724,  1004, -946,   569},
    '{724, -1004,  946,  -851,  724,  -569,  392,  -200}
  };

  // Clamp v into the signed range of an out_w-bit word.
  function automatic longint sat_clip(input longint v, input int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - 1;
    lo = -(longint'(1) <<< (out_w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/idct_coef_rom.sv
// Combinational cosine ROM: presents column k of the IDCT matrix,
// coefficient for output n in slice [n*COEF_W +: COEF_W].
module idct_coef_rom
  import idct_pkg::*;
#(
  parameter int COEF_W = IDCT_COEF_W
) (
  input  logic [2:0]          k,
  output logic [8*COEF_W-1:0] coef_col
);

  // Table lookup for all eight rows of the selected column.
  always_comb begin
    coef_col = '0;
    for (int n = 0; n < 8; n++) begin
      coef_col[n*COEF_W +: COEF_W] = COEF_W'(IDCT_COEF[n][k]);
    end
  end

endmodule

// File: rtl/idct_one_dimensional.sv
// 8-point 1-D inverse DCT. One coefficient X[k] is multiplied against a full
// ROM column each MAC cycle so all eight outputs accumulate in parallel; the
// ROUND cycle rounds, saturates and registers the samples with a data_en pulse.
module idct_one_dimensional
  import idct_pkg::*;
#(
  parameter int IN_W   = IDCT_IN_W,
  parameter int OUT_W  = IDCT_OUT_W,
  parameter int COEF_W = IDCT_COEF_W,
  parameter int ACC_W  = IDCT_ACC_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [8*IN_W-1:0] idct_data_in,
  output logic [OUT_W-1:0]  idct_data_o_y0,
  output logic [OUT_W-1:0]  idct_data_o_y1,
  output logic [OUT_W-1:0]  idct_data_o_y2,
  output logic [OUT_W-1:0]  idct_data_o_y3,
  output logic [OUT_W-1:0]  idct_data_o_y4,
  output logic [OUT_W-1:0]  idct_data_o_y5,
  output logic [OUT_W-1:0]  idct_data_o_y6,
  output logic [OUT_W-1:0]  idct_data_o_y7,
  output logic              data_en,
  output logic              busy
);

  idct_state_e                    state;
  idct_state_e                    state_nxt;
  logic        [2:0]              k;
  logic        [8*IN_W-1:0]       x_cap;
  logic signed [ACC_W-1:0]        acc [8];
  logic signed [OUT_W-1:0]        y_q [8];
  logic                           data_en_q;
  logic        [8*COEF_W-1:0]     coef_col;
  logic signed [COEF_W-1:0]       coef_n [8];
  logic signed [IN_W-1:0]         x_k;
  logic signed [IN_W+COEF_W-1:0]  prod [8];
  logic                           load;

  // Round half-up with an arithmetic shift, then clamp to OUT_W bits.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] rc;
    logic signed [ACC_W-1:0] shifted;
    rc      = ACC_W'(ROUND_CONST);
    shifted = (a + rc) >>> ROUND_SHIFT;
    return OUT_W'(sat_clip(longint'(shifted), OUT_W));
  endfunction

  // A new block is accepted from IDLE, or back-to-back from ROUND.
  assign load = start && ((state == ST_IDLE) || (state == ST_ROUND));

  idct_coef_rom #(.COEF_W(COEF_W)) u_coef_rom (
    .k        (k),
    .coef_col (coef_col)
  );

  // Select X[k] (X0 sits in the MSBs) and form the eight full-precision products.
  always_comb begin
    x_k = x_cap[IN_W*(7 - int'(k)) +: IN_W];
    for (int n = 0; n < 8; n++) begin
      coef_n[n] = coef_col[n*COEF_W +: COEF_W];
      prod[n]   = x_k * coef_n[n];
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; start is ignored while accumulating.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_MAC;
      ST_MAC:   if (k == 3'd7) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = start ? ST_MAC : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state == ST_MAC);
  end

  // Capture, accumulate and output registers; ROUND reads acc before the clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      k         <= '0;
      x_cap     <= '0;
      data_en_q <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        acc[n] <= '0;
        y_q[n] <= '0;
      end
    end else begin
      data_en_q <= (state == ST_ROUND);
      if (state == ST_ROUND) begin
        for (int n = 0; n < 8; n++) y_q[n] <= round_sat(acc[n]);
      end
      if (load) begin
        x_cap <= idct_data_in;
        k     <= '0;
        for (int n = 0; n < 8; n++) acc[n] <= '0;
      end else if (state == ST_MAC) begin
        k <= k + 3'd1;
        for (int n = 0; n < 8; n++) acc[n] <= acc[n] + ACC_W'(prod[n]);
      end
    end
  end

  assign data_en        = data_en_q;
  assign idct_data_o_y0 = y_q[0];
  assign idct_data_o_y1 = y_q[1];
  assign idct_data_o_y2 = y_q[2];
  assign idct_data_o_y3 = y_q[3];
  assign idct_data_o_y4 = y_q[4];
  assign idct_data_o_y5 = y_q[5];
  assign idct_data_o_y6 = y_q[6];
  assign idct_data_o_y7 = y_q[7];

endmodule

// File: tb/tb_idct_one_dimensional.sv
// Bench for idct_one_dimensional: a 12-bit-output and an 8-bit-output instance
// share stimulus; a real-arithmetic IDCT model predicts every data_en result.
module tb_idct_one_dimensional;

  localparam real PI = 3.14159265358979323846;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [95:0] bus       = '0;

  logic [11:0] ya [8];
  logic [7:0]  ys [8];
  logic        en_a, busy_a, en_s, busy_s;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [95:0] q_a [$];
  logic [95:0] q_s [$];
  logic [95:0] cur_a, cur_s;

  int          xs [8] = '{38, 42, 47, 48, 49, 51, 51, 50};
  int          lat;
  int          seen;
  longint      y0_seen;
  logic [95:0] rb;
  real         s;

  idct_one_dimensional dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .idct_data_in(bus),
    .idct_data_o_y0(ya[0]), .idct_data_o_y1(ya[1]), .idct_data_o_y2(ya[2]),
    .idct_data_o_y3(ya[3]), .idct_data_o_y4(ya[4]), .idct_data_o_y5(ya[5]),
    .idct_data_o_y6(ya[6]), .idct_data_o_y7(ya[7]), .data_en(en_a), .busy(busy_a)
  );

  idct_one_dimensional #(.OUT_W(8)) dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .idct_data_in(bus),
    .idct_data_o_y0(ys[0]), .idct_data_o_y1(ys[1]), .idct_data_o_y2(ys[2]),
    .idct_data_o_y3(ys[3]), .idct_data_o_y4(ys[4]), .idct_data_o_y5(ys[5]),
    .idct_data_o_y6(ys[6]), .idct_data_o_y7(ys[7]), .data_en(en_s), .busy(busy_s)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int round_r(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic longint cref(input int n, input int k);
    real r;
    if (k == 0) r = 2048.0 / (2.0 * $sqrt(2.0));
    else        r = 1024.0 * $cos(real'((2*n+1)*k) * PI / 16.0);
    return longint'(round_r(r));
  endfunction

  function automatic longint model_y(input logic [95:0] b, input int n, input int out_w);
    longint acc;
    longint hi;
    longint lo;
    acc = 0;
    for (int k = 0; k < 8; k++)
      acc += longint'($signed(b[(7-k)*12 +: 12])) * cref(n, k);
    acc = (acc + 1024) >>> 11;
    hi  = (longint'(1) <<< (out_w - 1)) - 1;
    lo  = -(longint'(1) <<< (out_w - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc;
  endfunction

  function automatic logic [95:0] put(input logic [95:0] b, input int k, input int v);
    logic [95:0] r;
    r = b;
    r[(7-k)*12 +: 12] = 12'(v);
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic issue(input logic [95:0] b);
    start = 1'b1;
    bus   = b;
    q_a.push_back(b);
    q_s.push_back(b);
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_en(output int l);
    l = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge sys_clk); #1;
      if (en_a) begin
        l = i;
        break;
      end
    end
  endtask

  // Scoreboard for the 12-bit instance.
  always @(negedge sys_clk) begin
    if (sys_rst_n && en_a) begin
      if (q_a.size() == 0) chk("unexpected data_en 12b", 1, 0);
      else begin
        cur_a = q_a.pop_front();
        for (int n = 0; n < 8; n++)
          chk($sformatf("model y%0d 12b", n), longint'($signed(ya[n])), model_y(cur_a, n, 12));
      end
    end
  end

  // Scoreboard for the 8-bit (saturating) instance.
  always @(negedge sys_clk) begin
    if (sys_rst_n && en_s) begin
      if (q_s.size() == 0) chk("unexpected data_en 8b", 1, 0);
      else begin
        cur_s = q_s.pop_front();
        for (int n = 0; n < 8; n++)
          chk($sformatf("model y%0d 8b", n), longint'($signed(ys[n])), model_y(cur_s, n, 8));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk); #1;
    chk("reset data_en", en_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset y0", ya[0], 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("idle busy", busy_a, 0);

    // DC only
    issue(put('0, 0, 100));
    chk("busy in MAC", busy_a, 1);
    chk("busy in MAC 8b", busy_s, 1);
    wait_en(lat);
    chk("latency dc", lat, 9);
    for (int n = 0; n < 8; n++) chk($sformatf("dc+ y%0d", n), $signed(ya[n]), 35);
    chk("busy after done", busy_a, 0);
    issue(put('0, 0, -100));
    wait_en(lat);
    for (int n = 0; n < 8; n++) chk($sformatf("dc- y%0d", n), $signed(ya[n]), -35);

    // First harmonic
    issue(put('0, 1, 100));
    wait_en(lat);
    chk("h1 y0", $signed(ya[0]), 49);
    chk("h1 y1", $signed(ya[1]), 42);
    chk("h1 y3", $signed(ya[3]), 10);
    chk("h1 y7", $signed(ya[7]), -49);
    for (int n = 0; n < 8; n++)
      chk($sformatf("h1 sym y%0d", n), $signed(ya[n]), -longint'($signed(ya[7-n])));

    // Saturation on the 8-bit instance
    issue(put('0, 0, 1000));
    wait_en(lat);
    for (int n = 0; n < 8; n++) chk($sformatf("sat+ y%0d", n), $signed(ys[n]), 127);
    chk("nosat+ 12b y0", $signed(ya[0]), 354);
    issue(put('0, 0, -1000));
    wait_en(lat);
    for (int n = 0; n < 8; n++) chk($sformatf("sat- y%0d", n), $signed(ys[n]), -128);
    chk("nosat- 12b y0", $signed(ya[0]), -354);

    // Back-to-back with dropped starts during MAC
    issue(put('0, 0, 100));
    repeat (8) @(posedge sys_clk); #1;
    chk("round cycle busy", busy_a, 0);
    chk("round cycle data_en", en_a, 0);
    issue(put('0, 0, 200));
    chk("b2b first data_en", en_a, 1);
    chk("b2b first y0", $signed(ya[0]), 35);
    chk("b2b busy", busy_a, 1);
    lat = -1;
    y0_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      start = (i == 3) || (i == 5);
      bus   = {$urandom, $urandom, $urandom};
      @(posedge sys_clk); #1;
      start = 1'b0;
      if (en_a && lat < 0) begin
        lat = i;
        y0_seen = $signed(ya[0]);
      end
    end
    chk("b2b second latency", lat, 9);
    chk("b2b second y0", y0_seen, 71);
    repeat (12) @(posedge sys_clk); #1;

    // Reset during MAC cycle 4
    start = 1'b1;
    bus   = put('0, 0, 100);
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk); #1;
    chk("pre-reset busy", busy_a, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid reset data_en", en_a, 0);
    chk("mid reset busy", busy_a, 0);
    chk("mid reset y0", ya[0], 0);
    chk("mid reset 8b y0", ys[0], 0);
    repeat (2) @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk); #1;
      if (en_a || en_s) seen++;
    end
    chk("no stale data_en", seen, 0);
    issue(put('0, 0, -100));
    wait_en(lat);
    chk("post-reset latency", lat, 9);
    chk("post-reset y0", $signed(ya[0]), -35);

    // Round trip of a forward-DCT row
    rb = '0;
    for (int k = 0; k < 8; k++) begin
      s = 0.0;
      for (int n = 0; n < 8; n++) s += real'(xs[n]) * $cos(real'((2*n+1)*k) * PI / 16.0);
      s = s * ((k == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0;
      rb = put(rb, k, round_r(s));
    end
    issue(rb);
    wait_en(lat);
    for (int n = 0; n < 8; n++) begin
      longint d;
      d = longint'($signed(ya[n])) - xs[n];
      chk($sformatf("roundtrip y%0d=%0d vs x=%0d within1", n, $signed(ya[n]), xs[n]),
          ((d <= 1) && (d >= -1)) ? 1 : 0, 1);
    end

    // Randomized blocks, back-to-back or with gaps
    for (int b = 0; b < 30; b++) begin
      rb = '0;
      for (int k = 0; k < 8; k++) begin
        if (b % 3 == 0) rb = put(rb, k, int'($urandom_range(0, 4095)) - 2048);
        else            rb = put(rb, k, int'($urandom_range(0, 400)) - 200);
      end
      issue(rb);
      repeat (8) @(posedge sys_clk); #1;
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      #1;
    end
    repeat (15) @(posedge sys_clk); #1;
    chk("queue drained 12b", q_a.size(), 0);
    chk("queue drained 8b", q_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idct_one_dimensional.md
Name: idct_one_dimensional

Overview:
8-point 1-D inverse DCT for the MJPEG decode path. It is the inverse counterpart of the forward DCT_one_dimensional stage.
- Accepts one 8-coefficient row or column as a packed bus, qualified by a start pulse.
- Computes y[n] = sum over k of X[k]*C[n][k] with one serial multiply-accumulate step per k. All 8 outputs are accumulated in parallel.
- Emits 8 signed samples with a one-cycle data_en pulse.
- Two instances around a transpose ping-pong buffer form the 2-D IDCT.

Parameters:
IN_W, 12, signed width of each input coefficient
OUT_W, 12, signed width of each output sample (saturated)
COEF_W, 12, signed width of the cosine constants (scale 2^11)
ACC_W, 28, accumulator width (IN_W+COEF_W+3, +1 guard)

Ports:
sys_clk  in  1  clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; idct_data_in is valid in the same cycle
idct_data_in  in  8*IN_W  packed coefficients; X0 in [95:84] down to X7 in [11:0] (MSB first)
idct_data_o_y0..idct_data_o_y7  out  OUT_W each  signed output samples y0..y7
data_en  out  1  one-cycle pulse; outputs are valid in that cycle
busy  out  1  high while state is MAC

Behaviour:
Reset, asynchronous:
- state=IDLE, k=0.
- Accumulators, capture register, all y outputs, data_en and busy are 0.
- Reset mid-operation aborts the block; no data_en is produced.

Coefficients:
- C[n][k] = round(2048 * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt(2) and c(k>0)=1.
- Examples: C[n][0]=724; C[0][1]=1004; C[7][1]=-1004.

FSM states: IDLE, MAC, ROUND.
- IDLE: start=1 → register idct_data_in, clear all 8 accumulators, k=0, go to MAC.
- MAC: each cycle acc[n] += X[k]*C[n][k] for n=0..7, with a full-precision signed product. k increments; after k=7, go to ROUND. start is ignored (dropped) in MAC.
- ROUND, for each n:
  - y_n = sat_OUT_W((acc[n] + 1024) >>> 11), using an arithmetic shift.
  - Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register y_n to the outputs and pulse data_en=1 for exactly 1 cycle; go to IDLE.
  - If start=1 in ROUND, the new block is captured on the same edge (back-to-back) and the next state is MAC. The accumulator clear and the rounding read use the pre-edge values.

Timing:
- Latency: start sampled at edge E0 → data_en high and outputs updated from edge E9 (9 cycles).
- Max throughput: one block per 9 cycles.

Outputs:
- Outputs hold their last value between pulses.
- data_en is low in all non-ROUND-exit cycles.
- busy=1 exactly in MAC cycles.

Decomposition:
- Package idct_pkg:
  - IN_W/OUT_W/COEF_W/ACC_W defaults.
  - Rounding constant 1024 and shift 11.
  - 8x8 signed coefficient constant table.
  - Saturation function.
- Sub-module idct_coef_rom: combinational; input k[2:0]; outputs the 8 coefficients of column k (C[0..7][k]). It is shared by the MAC datapath.
- FSM, accumulators and output registers stay in idct_one_dimensional.

Test Plan:
1. DC only: X0=100, others 0, start pulse → data_en 9 cycles later; y0..y7 all 35. Then X0=-100 → all -35.
2. First harmonic: X1=100, others 0 → y0=49, y7=-49, with y[n]=-y[7-n] symmetry held for all n.
3. Saturation: OUT_W=8 instance, X0=1000 → all outputs 127; X0=-1000 → all -128.
4. Back-to-back: start in the ROUND cycle with a new bus (X0=200) → first data_en outputs 35, second data_en 9 cycles later outputs 71. start pulses during MAC are dropped, giving no extra data_en.
5. Reset mid-block: deassert sys_rst_n during MAC cycle 4 → outputs/data_en/busy immediately 0. After release, no stale data_en; a new start works normally.
6. Round-trip: forward DCT_one_dimensional row {38,42,47,48,49,51,51,50} fed through this block (IN_W=12) → reconstructed samples within ±1 of the originals.
